interp_data_loader: RTL and testbench

INTERP_DATA_LOADER -- requirements
Module: interp_data_loader

---
 rtl/interp_data_loader.sv | 174 +++++++++++++++++
 tb/tb_interp_data_loader.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interp_data_loader.sv
// Streams m, the time points and the u vectors from the host into RAM, then pulses init_sg.
// Optional LOADER_CHECKSUM_EN: a trailing checksum word is checked before init_sg is issued.
module interp_data_loader #(
  parameter int WORD_SIZE     = 16,
  parameter int ADDRESS_WIDTH = 16,
  parameter int MAX_POINTS    = 8,
  parameter int T_BASE        = 1,
  parameter int U_BASE        = 10,
  parameter int U_STRIDE      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [WORD_SIZE-1:0]     in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [ADDRESS_WIDTH-1:0] ram_add,
  output logic [WORD_SIZE-1:0]     ram_data,
  output logic                     mem_write,
  output logic                     init_sg,
  output logic                     busy,
  output logic                     err
);

  localparam int IW = $clog2(MAX_POINTS + 1);
  localparam int CW = (U_STRIDE > 1) ? $clog2(U_STRIDE) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_TIME = 3'd2,
    S_VEC  = 3'd3,
`ifdef LOADER_CHECKSUM_EN
    S_CHK  = 3'd4,
`endif
    S_DONE = 3'd5
  } state_t;

  state_t         state;
  logic [IW-1:0]  idx;
  logic [IW-1:0]  m_last;
  logic [CW-1:0]  comp;
`ifdef LOADER_CHECKSUM_EN
  logic [WORD_SIZE-1:0] sum;
`endif

  logic xfer;
  logic last_comp;
  logic last_idx;

  assign xfer      = in_valid && in_ready;
  assign last_comp = (comp == CW'(U_STRIDE - 1));
  assign last_idx  = (idx == m_last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      m_last    <= '0;
      comp      <= '0;
      in_ready  <= 1'b0;
      mem_write <= 1'b0;
      init_sg   <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      ram_add   <= '0;
      ram_data  <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum       <= '0;
`endif
    end else begin
      mem_write <= 1'b0;
      init_sg   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      if (xfer) sum <= sum + in_data;
`endif
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_HDR;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            err      <= 1'b0;
            idx      <= '0;
            comp     <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum      <= '0;
`endif
          end
        end
        S_HDR: begin
          if (xfer) begin
            if (in_data != '0 && in_data <= WORD_SIZE'(MAX_POINTS)) begin
              m_last    <= IW'(in_data - 1'b1);
              mem_write <= 1'b1;
              ram_add   <= '0;
              ram_data  <= in_data;
              idx       <= '0;
              state     <= S_TIME;
            end else begin
              err      <= 1'b1;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              state    <= S_IDLE;
            end
          end
        end
        S_TIME: begin
          if (xfer) begin
            mem_write <= 1'b1;
            ram_add   <= ADDRESS_WIDTH'(T_BASE) + ADDRESS_WIDTH'(idx);
            ram_data  <= in_data;
            if (last_idx) begin
              idx   <= '0;
              comp  <= '0;
              state <= S_VEC;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        S_VEC: begin
          if (xfer) begin
            mem_write <= 1'b1;
            ram_add   <= ADDRESS_WIDTH'(U_BASE) + ADDRESS_WIDTH'(idx) * ADDRESS_WIDTH'(U_STRIDE)
                         + ADDRESS_WIDTH'(comp);
            ram_data  <= in_data;
            if (last_comp) begin
              comp <= '0;
              if (last_idx) begin
`ifdef LOADER_CHECKSUM_EN
                state <= S_CHK;
`else
                in_ready <= 1'b0;
                state    <= S_DONE;
`endif
              end else begin
                idx <= idx + IW'(1);
              end
            end else begin
              comp <= comp + CW'(1);
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHK: begin
          // The checksum word itself is never written to RAM.
          if (xfer) begin
            in_ready <= 1'b0;
            if (in_data == sum) begin
              state <= S_DONE;
            end else begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
        end
`endif
        S_DONE: begin
          init_sg <= 1'b1;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
        default: begin
          in_ready <= 1'b0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interp_data_loader.sv
// Directed bench for interp_data_loader: logs every RAM write and init_sg pulse at the falling edge.
module tb_interp_data_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] ram_add;
  logic [15:0] ram_data;
  logic        mem_write;
  logic        init_sg;
  logic        busy;
  logic        err;

  int compared;
  int mismatched;
  int cyc;
  int both_cnt;
  int w_add[$];
  int w_dat[$];
  int w_cyc[$];
  int init_cyc[$];

`ifdef LOADER_CHECKSUM_EN
  localparam int INIT_LAT = 2;
`else
  localparam int INIT_LAT = 1;
`endif

  interp_data_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ram_add   (ram_add),
    .ram_data  (ram_data),
    .mem_write (mem_write),
    .init_sg   (init_sg),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mem_write) begin
      w_add.push_back(int'(ram_add));
      w_dat.push_back(int'(ram_data));
      w_cyc.push_back(cyc);
    end
    if (init_sg) init_cyc.push_back(cyc);
    if (init_sg && err) both_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    w_add.delete();
    w_dat.delete();
    w_cyc.delete();
    init_cyc.delete();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] w);
    int n;
    in_data  = w;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout: in_ready=%0b, required 1 for word %0d", in_ready, w);
    end else begin
      tick();
    end
  endtask

  task automatic send_gap(input logic [15:0] w, input int gap);
    in_valid = 1'b0;
    repeat (gap) tick();
    send(w);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    repeat (2) tick();
    compared++;
    if (in_ready !== 1'b0 || mem_write !== 1'b0 || init_sg !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_ctrl: in_ready=%0b mem_write=%0b init_sg=%0b, required 0 0 0", in_ready, mem_write, init_sg);
    end
    compared++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_status: busy=%0b err=%0b, required 0 0", busy, err);
    end
    compared++;
    if (ram_add !== 16'd0 || ram_data !== 16'd0) begin
      mismatched++;
      $display("FAIL reset_bus: ram_add=%0d ram_data=%0d, required 0 0", ram_add, ram_data);
    end
    rst = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_contiguous();
    int ea[11];
    int ed[11];
    ea = '{0, 1, 2, 10, 11, 12, 13, 14, 15, 16, 17};
    ed = '{2, 5, 9, 1, 2, 3, 4, 5, 6, 7, 8};
    clear_log();
    do_start();
    compared++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL contig_start: busy=%0b in_ready=%0b, required 1 1", busy, in_ready);
    end
    for (int i = 0; i < 11; i++) send(ed[i][15:0]);
`ifdef LOADER_CHECKSUM_EN
    send(16'd52);
`endif
    in_valid = 1'b0;
    repeat (4) tick();
    compared++;
    if (w_add.size() !== 11) begin
      mismatched++;
      $display("FAIL contig_count: writes=%0d, required 11", w_add.size());
    end
    for (int i = 0; i < 11 && i < w_add.size(); i++) begin
      compared++;
      if (w_add[i] !== ea[i] || w_dat[i] !== ed[i] || w_cyc[i] !== w_cyc[0] + i) begin
        mismatched++;
        $display("FAIL contig_write%0d: add=%0d dat=%0d cyc=%0d, required %0d %0d %0d",
                 i, w_add[i], w_dat[i], w_cyc[i], ea[i], ed[i], w_cyc[0] + i);
      end
    end
    compared++;
    if (init_cyc.size() !== 1) begin
      mismatched++;
      $display("FAIL contig_init_count: pulses=%0d, required 1", init_cyc.size());
    end else if (w_cyc.size() == 11) begin
      compared++;
      if (init_cyc[0] !== w_cyc[10] + INIT_LAT) begin
        mismatched++;
        $display("FAIL contig_init_time: cyc=%0d, required %0d", init_cyc[0], w_cyc[10] + INIT_LAT);
      end
    end
    compared++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      mismatched++;
      $display("FAIL contig_end: busy=%0b err=%0b, required 0 0", busy, err);
    end
  endtask

  task automatic test_bad_header(input logic [15:0] m);
    clear_log();
    do_start();
    send(m);
    in_valid = 1'b0;
    compared++;
    if (err !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL bad_m%0d_flags: err=%0b in_ready=%0b busy=%0b, required 1 0 0", m, err, in_ready, busy);
    end
    repeat (3) tick();
    compared++;
    if (w_add.size() !== 0 || init_cyc.size() !== 0) begin
      mismatched++;
      $display("FAIL bad_m%0d_quiet: writes=%0d init=%0d, required 0 0", m, w_add.size(), init_cyc.size());
    end
    compared++;
    if (err !== 1'b1) begin
      mismatched++;
      $display("FAIL bad_m%0d_sticky: err=%0b, required 1", m, err);
    end
  endtask

  task automatic test_stall();
    int ea[6];
    int ed[6];
    ea = '{0, 1, 10, 11, 12, 13};
    ed = '{1, 7, 3, 4, 5, 6};
    clear_log();
    do_start();
    compared++;
    if (err !== 1'b0) begin
      mismatched++;
      $display("FAIL stall_err_clear: err=%0b, required 0", err);
    end
    send(ed[0][15:0]);
    for (int i = 1; i < 6; i++) send_gap(ed[i][15:0], 2);
`ifdef LOADER_CHECKSUM_EN
    send_gap(16'd26, 2);
`endif
    in_valid = 1'b0;
    repeat (4) tick();
    compared++;
    if (w_add.size() !== 6 || init_cyc.size() !== 1) begin
      mismatched++;
      $display("FAIL stall_count: writes=%0d init=%0d, required 6 1", w_add.size(), init_cyc.size());
    end
    for (int i = 0; i < 6 && i < w_add.size(); i++) begin
      compared++;
      if (w_add[i] !== ea[i] || w_dat[i] !== ed[i]) begin
        mismatched++;
        $display("FAIL stall_write%0d: add=%0d dat=%0d, required %0d %0d", i, w_add[i], w_dat[i], ea[i], ed[i]);
      end
    end
    for (int i = 1; i < 6 && i < w_cyc.size(); i++) begin
      compared++;
      if (w_cyc[i] - w_cyc[i-1] !== 3) begin
        mismatched++;
        $display("FAIL stall_spacing%0d: gap=%0d, required 3", i, w_cyc[i] - w_cyc[i-1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    do_start();
    send(16'd2);
    send(16'd5);
    send(16'd9);
    @(negedge clk);
    #1;
    rst = 1'b0;
    in_data = 16'd1;
    #1;
    compared++;
    if (in_ready !== 1'b0 || mem_write !== 1'b0 || init_sg !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      mismatched++;
      $display("FAIL rstmid_ctrl: in_ready=%0b mem_write=%0b init_sg=%0b busy=%0b err=%0b, required all 0",
               in_ready, mem_write, init_sg, busy, err);
    end
    compared++;
    if (ram_add !== 16'd0 || ram_data !== 16'd0) begin
      mismatched++;
      $display("FAIL rstmid_bus: ram_add=%0d ram_data=%0d, required 0 0", ram_add, ram_data);
    end
    tick();
    tick();
    rst = 1'b1;
    repeat (3) tick();
    compared++;
    if (w_add.size() !== 3 || busy !== 1'b0 || in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL rstmid_abort: writes=%0d busy=%0b in_ready=%0b, required 3 0 0", w_add.size(), busy, in_ready);
    end
    clear_log();
    do_start();
    send(16'd1);
    send(16'd7);
    for (int v = 3; v <= 6; v++) send(16'(v));
`ifdef LOADER_CHECKSUM_EN
    send(16'd26);
`endif
    in_valid = 1'b0;
    repeat (4) tick();
    compared++;
    if (w_add.size() !== 6 || init_cyc.size() !== 1 || err !== 1'b0) begin
      mismatched++;
      $display("FAIL rstmid_reload: writes=%0d init=%0d err=%0b, required 6 1 0", w_add.size(), init_cyc.size(), err);
    end
  endtask

  task automatic test_start_during_vec();
    int ea[6];
    int ed[6];
    ea = '{0, 1, 10, 11, 12, 13};
    ed = '{1, 2, 4, 5, 6, 7};
    clear_log();
    do_start();
    send(16'd1);
    send(16'd2);
    send(16'd4);
    start = 1'b1;
    send(16'd5);
    start = 1'b0;
    send(16'd6);
    send(16'd7);
`ifdef LOADER_CHECKSUM_EN
    send(16'd25);
`endif
    in_valid = 1'b0;
    repeat (4) tick();
    compared++;
    if (w_add.size() !== 6 || init_cyc.size() !== 1 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL startvec_result: writes=%0d init=%0d busy=%0b, required 6 1 0", w_add.size(), init_cyc.size(), busy);
    end
    for (int i = 0; i < 6 && i < w_add.size(); i++) begin
      compared++;
      if (w_add[i] !== ea[i] || w_dat[i] !== ed[i]) begin
        mismatched++;
        $display("FAIL startvec_write%0d: add=%0d dat=%0d, required %0d %0d", i, w_add[i], w_dat[i], ea[i], ed[i]);
      end
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum(input logic [15:0] chk, input bit good);
    clear_log();
    do_start();
    send(16'd1);
    send(16'd3);
    for (int i = 0; i < 4; i++) send(16'd1);
    send(chk);
    in_valid = 1'b0;
    repeat (4) tick();
    compared++;
    if (w_add.size() !== 6) begin
      mismatched++;
      $display("FAIL chk%0d_writes: writes=%0d, required 6", chk, w_add.size());
    end
    compared++;
    if (init_cyc.size() !== (good ? 1 : 0) || err !== !good) begin
      mismatched++;
      $display("FAIL chk%0d_result: init=%0d err=%0b, required %0d %0b", chk, init_cyc.size(), err, good ? 1 : 0, !good);
    end
  endtask
`endif

  initial begin
    compared   = 0;
    mismatched = 0;
    cyc        = 0;
    both_cnt   = 0;
    test_reset();
    test_contiguous();
    test_bad_header(16'd0);
    test_bad_header(16'd9);
    test_stall();
    test_reset_mid();
    test_start_during_vec();
`ifdef LOADER_CHECKSUM_EN
    test_checksum(16'd8, 1'b1);
    test_checksum(16'd9, 1'b0);
`endif
    compared++;
    if (both_cnt !== 0) begin
      mismatched++;
      $display("FAIL err_with_init: cycles=%0d, required 0", both_cnt);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
